single_port_ram_arbiter: RTL and testbench

//  Shares one single_port_RAM instance between NUM_REQ requesters. It grants one access per

---
 rtl/spram_arb_pkg.sv | 12 +
 rtl/single_port_ram_arbiter_rr_arbiter.sv | 31 +++
 rtl/single_port_ram_arbiter.sv | 117 +++++++++++
 tb/tb_single_port_ram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spram_arb_pkg.sv
// Shared types and sizing helpers for the single-port RAM arbiter.
package spram_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(NUM_REQ_DEFAULT)-1:0] arb_idx_t;

endpackage

// File: rtl/single_port_ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
module rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEFAULT,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    logic [IW-1:0] cand;
    cand    = '0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Round-robin sharing of one registered, read-first single-port RAM among NUM_REQ clients;
// read data comes back two cycles after the grant, tagged with the requester's rsp_valid bit.
module single_port_ram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int IDX_WIDTH  = idx_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            err_range,
  output logic                            ram_write_en,
  output logic                            ram_read_en,
  output logic [ADDR_WIDTH-1:0]           ram_address,
  output logic [DATA_WIDTH-1:0]           ram_data_in,
  input  logic [DATA_WIDTH-1:0]           ram_data_out
);

  localparam logic [ADDR_WIDTH:0]  DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  logic [IDX_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  pend_q, pend_d;
  logic [IDX_WIDTH-1:0]  pend_idx_q, pend_idx_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    req_eff;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_WIDTH-1:0]  gnt_idx;
  logic                  gnt_any;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  in_range;
  logic                  ram_go;

  // Requests are masked while reset is held so nothing is granted or written to the RAM.
  assign req_eff = rst ? '0 : req_valid;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_WIDTH)
  ) u_rr (
    .req     (req_eff),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_we    = req_we[gnt_idx];
  assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign in_range  = ({1'b0, sel_addr} < DEPTH_W);
  assign ram_go    = gnt_any && in_range;

  assign req_ready    = gnt;
  assign ram_write_en = ram_go && sel_we;
  assign ram_read_en  = ram_go && !sel_we;
  assign ram_address  = ram_go ? sel_addr : '0;
  assign ram_data_in  = ram_go ? sel_wdata : '0;

  always_comb begin
    ptr_d       = ptr_q;
    pend_d      = ram_read_en;
    pend_idx_d  = pend_idx_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = gnt_any && !in_range;
    if (gnt_any) begin
      ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
    if (ram_read_en) begin
      pend_idx_d = gnt_idx;
    end
    // RAM data_out is valid the cycle after the read was issued.
    if (pend_q) begin
      rsp_valid_d[pend_idx_q] = 1'b1;
      rsp_rdata_d             = ram_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench: arbiter in front of a behavioural read-first RAM, plus a DEPTH=200 copy for range errors.
module tb_single_port_ram_arbiter;

  localparam int NR = 4, DW = 8, AW = 8, DEPTH = 256, SDEPTH = 200;

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, ram_data_in, ram_data_out;
  logic [AW-1:0]    ram_address;
  logic             err_range, ram_write_en, ram_read_en;

  logic [NR-1:0] s_ready, s_rsp_valid;
  logic [DW-1:0] s_rsp_rdata, s_din;
  logic [AW-1:0] s_addr;
  logic          s_err, s_we, s_re;

  always #5 clk = ~clk;

  single_port_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_range(err_range), .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
    .ram_address(ram_address), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  single_port_ram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(SDEPTH)) u_dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
    .err_range(s_err), .ram_write_en(s_we), .ram_read_en(s_re),
    .ram_address(s_addr), .ram_data_in(s_din), .ram_data_out(ram_data_out)
  );

  // Registered, read-first single-port RAM
  logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
  logic [DW-1:0] ram_dout = '0;
  always @(posedge clk) begin
    if (ram_write_en) ram_mem[ram_address] <= ram_data_in;
    if (ram_read_en)  ram_dout <= ram_mem[ram_address];
  end
  assign ram_data_out = ram_dout;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pointer, memory image and in-flight read responses
  int            m_ptr;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_last;
  bit            d1_v, d2_v, sd1_v, sd2_v, se1;
  int            d1_i, d2_i, sd1_i, sd2_i;
  logic [DW-1:0] d1_dat, d2_dat;

  logic [NR-1:0] obs_rsp_valid, obs_s_ready, obs_s_rsp_valid;
  logic [DW-1:0] obs_rsp_rdata;
  logic          obs_s_err;

  task automatic model_reset();
    m_ptr = 0; m_last = '0;
    d1_v = 0; d2_v = 0; sd1_v = 0; sd2_v = 0; se1 = 0;
  endtask

  task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic new_req(input int i);
    logic [AW-1:0] a;
    a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    set_req(i, ($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)), a, DW'($urandom));
  endtask

  task automatic check_rst(input string tag);
    check_eq({tag, "_main"}, 64'({req_ready, rsp_valid, rsp_rdata, err_range, ram_write_en,
                                  ram_read_en, ram_address, ram_data_in}), 64'd0);
    check_eq({tag, "_small"}, 64'({s_ready, s_rsp_valid, s_err, s_we, s_re, s_addr, s_din}), 64'd0);
  endtask

  // One clock cycle: check outputs against the model at the falling edge, then advance it.
  task automatic step(output int w);
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          we;
    bit            s_oor;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    obs_rsp_valid = rsp_valid; obs_rsp_rdata = rsp_rdata;
    obs_s_ready = s_ready; obs_s_err = s_err; obs_s_rsp_valid = s_rsp_valid;
    if (d2_v) m_last = d2_dat;
    check_eq("rsp_valid", 64'(rsp_valid), d2_v ? (64'd1 << d2_i) : 64'd0);
    check_eq("rsp_rdata", 64'(rsp_rdata), 64'(m_last));
    check_eq("err_range", 64'(err_range), 64'd0);
    check_eq("s_err_range", 64'(s_err), 64'(se1));
    check_eq("s_rsp_valid", 64'(s_rsp_valid), sd2_v ? (64'd1 << sd2_i) : 64'd0);
    w = -1;
    for (int k = 0; k < NR; k++) begin
      c = (m_ptr + k) % NR;
      if (w < 0 && req_valid[c]) w = c;
    end
    exp_ready = (w < 0) ? '0 : NR'(1 << w);
    check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
    check_eq("s_req_ready", 64'(s_ready), 64'(exp_ready));
    a = '0; we = 1'b0; wd = '0; s_oor = 0;
    if (w >= 0) begin
      a = req_addr[w*AW +: AW]; we = req_we[w]; wd = req_wdata[w*DW +: DW];
      s_oor = (int'(a) >= SDEPTH);
    end
    check_eq("ram_pins", 64'({ram_write_en, ram_read_en, ram_address, ram_data_in}),
             (w < 0) ? 64'd0 : 64'({we, !we, a, wd}));
    check_eq("s_ram_pins", 64'({s_we, s_re, s_addr, s_din}),
             (w < 0 || s_oor) ? 64'd0 : 64'({we, !we, a, wd}));
    d2_v = d1_v; d2_i = d1_i; d2_dat = d1_dat;
    d1_v = (w >= 0) && !we; d1_i = w; d1_dat = (w >= 0) ? m_mem[a] : '0;
    if (w >= 0 && we) m_mem[a] = wd;
    sd2_v = sd1_v; sd2_i = sd1_i;
    sd1_v = (w >= 0) && !we && !s_oor; sd1_i = w;
    se1 = (w >= 0) && s_oor;
    if (w >= 0) m_ptr = (w + 1) % NR;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    // Reset with every requester valid
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), '0);
    @(negedge clk); #1;
    check_rst("rst_assert");
    @(posedge clk); #1;
    check_rst("rst_hold");
    rst = 1'b0;
    model_reset();

    // All valid: strict rotation starting at requester 0
    for (int k = 0; k < 8; k++) begin
      step(w);
      check_eq("rr_order", 64'(w), 64'(k % NR));
      if (w >= 0) set_req(w, 1'b1, 1'b0, AW'($urandom), '0);
    end
    idle_all();
    step(w); step(w);

    // Write then read-after-write from another requester
    set_req(1, 1'b1, 1'b1, 8'h10, 8'hA5);
    step(w);
    check_eq("t3_wr_grant", 64'(w), 64'd1);
    idle_all();
    set_req(2, 1'b1, 1'b0, 8'h10, 8'h00);
    step(w);
    idle_all();
    step(w); step(w);
    check_eq("t3_rsp", 64'({obs_rsp_valid, obs_rsp_rdata}), 64'({4'b0100, 8'hA5}));

    // Consecutive reads at both ends of the address space
    set_req(0, 1'b1, 1'b1, 8'h00, 8'h3C); step(w); idle_all();
    set_req(3, 1'b1, 1'b1, 8'hFF, 8'hC3); step(w); idle_all();
    set_req(0, 1'b1, 1'b0, 8'h00, 8'h00); step(w); idle_all();
    set_req(3, 1'b1, 1'b0, 8'hFF, 8'h00); step(w); idle_all();
    step(w);
    check_eq("t4_rsp0", 64'({obs_rsp_valid, obs_rsp_rdata}), 64'({4'b0001, 8'h3C}));
    step(w);
    check_eq("t4_rsp3", 64'({obs_rsp_valid, obs_rsp_rdata}), 64'({4'b1000, 8'hC3}));

    // Address == DEPTH on the smaller instance
    set_req(2, 1'b1, 1'b0, 8'(SDEPTH), 8'h00);
    step(w);
    check_eq("t5_ready", 64'(obs_s_ready), 64'(4'b0100));
    idle_all();
    step(w);
    check_eq("t5_err", 64'(obs_s_err), 64'd1);
    step(w);
    check_eq("t5_no_rsp", 64'(obs_s_rsp_valid), 64'd0);
    step(w);

    // Reset between a read grant and its response
    set_req(1, 1'b1, 1'b0, 8'h10, 8'h00);
    step(w);
    idle_all();
    @(negedge clk); rst = 1'b1; #1;
    check_rst("t6_rst");
    @(posedge clk); #1;
    check_rst("t6_rst_edge");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 8'h10, 8'h00);
    step(w);
    check_eq("t6_ptr0", 64'(w), 64'd0);
    idle_all();
    step(w); step(w); step(w);

    // Randomized traffic; an ungranted request is held unchanged
    for (int i = 0; i < NR; i++) new_req(i);
    for (int n = 0; n < 600; n++) begin
      step(w);
      for (int i = 0; i < NR; i++)
        if (i == w || !req_valid[i]) new_req(i);
    end
    idle_all();
    step(w); step(w); step(w);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
